// File: rtl/codeword_framer.sv
// codeword_framer: cuts a raw word stream into BLOCK_LEN-word codewords, padding short blocks.
// Ports:
//    clock, reset          - rising-edge clock, synchronous active-low reset
//    data_in_*             - raw word stream (data/valid/ready/tlast), slave side
//    data_out_*            - framed stream to the decoder (data/valid/ready/tlast), master side
//    blocks_padded         - saturating count of blocks that needed padding
module codeword_framer #(
   parameter int          BLOCK_LEN = 6,
   parameter logic [31:0] PAD_WORD  = 32'h0000_0000,
   parameter int          TIMEOUT   = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_in_data,
   input  logic        data_in_valid,
   output logic        data_in_ready,
   input  logic        data_in_tlast,
   output logic [31:0] data_out_data,
   output logic        data_out_valid,
   input  logic        data_out_ready,
   output logic        data_out_tlast,
   output logic [15:0] blocks_padded
);
   localparam int WW = $clog2(BLOCK_LEN);
   localparam logic [WW-1:0] LAST = WW'(BLOCK_LEN - 1);
   localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT - 1);
   typedef enum logic {FILL, PAD} state_t;
   state_t state, state_nx;
   logic [WW-1:0] wcnt, wcnt_nx;
   logic [15:0] idle, idle_nx;
   logic can_load, accept, last, load, pad_inc;
   always_comb begin
      can_load = !data_out_valid || data_out_ready;
      // reset gates ready so nothing is handshaken while the block is held in reset
      data_in_ready = reset && (state == FILL) && can_load;
      accept = data_in_valid && data_in_ready;
      last = wcnt == LAST;
      load = accept || ((state == PAD) && can_load);
      wcnt_nx = load ? (last ? '0 : wcnt + 1'b1) : wcnt;
      state_nx = state;
      idle_nx = idle;
      pad_inc = 1'b0;
      if (state == FILL) begin
         if (accept) begin
            idle_nx = '0;
            if (data_in_tlast && !last) begin
               state_nx = PAD;
               pad_inc = 1'b1;
            end
         end else if (wcnt != '0) begin
            // keeps counting under output backpressure; PAD waits for the stage to free
            if (idle == IDLE_MAX) begin
               state_nx = PAD;
               pad_inc = 1'b1;
               idle_nx = '0;
            end else begin
               idle_nx = idle + 16'd1;
            end
         end
      end else if (can_load && last) begin
         state_nx = FILL;
         idle_nx = '0;
      end
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= FILL;
         wcnt <= '0;
         idle <= '0;
         data_out_valid <= 1'b0;
         data_out_tlast <= 1'b0;
         data_out_data <= '0;
         blocks_padded <= '0;
      end else begin
         state <= state_nx;
         wcnt <= wcnt_nx;
         idle <= idle_nx;
         if (load) begin
            data_out_valid <= 1'b1;
            data_out_data <= accept ? data_in_data : PAD_WORD;
            data_out_tlast <= last;
         end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
         end
         if (pad_inc && blocks_padded != 16'hFFFF) blocks_padded <= blocks_padded + 16'd1;
      end
   end
endmodule
